regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: the ALU writeback path (requester A, normal priority winner) and the memory/load completion path (requester B). A fixed-priority arbiter with a starvation counter guarantees B is served within a bounded number of cycles. The block registers the winning request and drives the register file's `WriteReg`/`DstReg`/`DstData` inputs one cycle after acceptance. Writes to `$0` are accepted and silently dropped.

## Interface

Parameters:
- `STARVE_LIMIT`, default 3: number of consecutive cycles B may be refused while valid before it is force-granted. Legal range is 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `hold`  in  1  write-port stall; while high, no grants are issued and the starvation counter is frozen.
- `a_valid`  in  1  A has a write pending.
- `a_reg`  in  4  A destination register.
- `a_data`  in  16  A write data.
- `a_ready`  out  1  A request accepted this cycle.
- `b_valid`  in  1  B has a write pending.
- `b_reg`  in  4  B destination register.
- `b_data`  in  16  B write data.
- `b_ready`  out  1  B request accepted this cycle.
- `WriteReg`  out  1  register file write enable (registered).
- `DstReg`  out  4  register file write address (registered).
- `DstData`  out  16  register file write data (registered).
- `b_forced`  out  1  high in the cycle B is granted because of starvation.

## Operation

- Handshake: a transfer occurs when `x_valid && x_ready` are both high in the same cycle. A requester must hold `valid`, `reg` and `data` stable until it sees `ready`; the block does not check this.
- `ready` is combinational from `hold`, `a_valid`, `b_valid` and the starvation count. It never depends on `ready`, so requesters must not make `valid` depend on `ready`.
- Grant selection, evaluated each cycle when `hold` is low:
  - If `b_valid` and `starve_cnt == STARVE_LIMIT`: grant B and assert `b_forced`.
  - Else if `a_valid`: grant A.
  - Else if `b_valid`: grant B.
  - Else: no grant.
- When `hold` is high, `a_ready = b_ready = b_forced = 0`.
- At most one of `a_ready`/`b_ready` is high in any cycle.
- Starvation counter `starve_cnt` (4 bits, saturating):
  - When `hold` is high: holds its value.
  - Else if `b_valid && !b_ready`: increments, saturating at `STARVE_LIMIT`.
  - Else: clears to 0. This covers both a B grant and `b_valid` being low.
- Output stage:
  - On an accepted transfer, at the next edge `DstReg`/`DstData` load the winner's reg/data, and `WriteReg` loads `(reg != 0)`.
  - In cycles with no transfer, `WriteReg` loads 0 and `DstReg`/`DstData` hold their previous values.
- A and B targeting the same register in the same cycle: they are serialized by the grant order, and the later-written value persists. No merging is performed.
- Throughput is one write per cycle. With B continuously valid alongside A, B gets at least 1 grant in every `STARVE_LIMIT+1` cycles.

## Timing

- Reset values: `WriteReg=0`, `DstReg=0`, `DstData=0`, `starve_cnt=0`. With all inputs low during reset, `a_ready=b_ready=b_forced=0`.
- Reset asserted mid-operation clears all state immediately. A registered write not yet presented is discarded, and no write is issued in the cycle after reset deasserts unless a new transfer is accepted.
- Latency: a transfer accepted in cycle N drives `WriteReg`/`DstReg`/`DstData` during cycle N+1, and the register file captures the write at the end of cycle N+1.
- `hold` takes effect combinationally in the same cycle. A write already registered before `hold` rose is still driven in the following cycle.
- `b_forced` is combinational and coincides with `b_ready`.

## Test plan

- Reset, then A only: `a_valid=1`, `a_reg=5`, `a_data=16'h1234` for 1 cycle -> `a_ready=1` that cycle; next cycle `WriteReg=1`, `DstReg=5`, `DstData=16'h1234`; the cycle after, `WriteReg=0`.
- Simultaneous requests: A (reg 3, `16'hAAAA`) and B (reg 4, `16'hBBBB`) valid together, with A dropping after acceptance -> A granted in cycle 0 and written in cycle 1; B granted in cycle 1 and written in cycle 2.
- Starvation, `STARVE_LIMIT=3`: A valid continuously with new data each cycle, B valid with reg 7 -> B refused in cycles 0-2; in cycle 3 `b_ready=1`, `b_forced=1`, `a_ready=0`; in cycle 4 `WriteReg=1`, `DstReg=7`; counter restarts from 0.
- `$0` drop: B writes reg 0, `16'hFFFF` -> `b_ready=1`; next cycle `WriteReg=0`.
- Hold: `hold=1` for 4 cycles with A and B both valid -> no readies and the counter is frozen. Release `hold` with `starve_cnt=2` and `STARVE_LIMIT=3` -> B is forced after exactly one more refusal.
- Async reset mid-write: assert `rst` between acceptance (cycle N) and its output cycle -> outputs go to 0 immediately, and `WriteReg` stays 0 after release with no valids present.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between ALU writeback (A)
// and load completion (B), with a starvation bound on B and a registered write stage.
module regfile_write_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        a_valid,
  input  logic [3:0]  a_reg,
  input  logic [15:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [3:0]  b_reg,
  input  logic [15:0] b_data,
  output logic        b_ready,
  output logic        WriteReg,
  output logic [3:0]  DstReg,
  output logic [15:0] DstData,
  output logic        b_forced
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // Handshake: a transfer happens when valid and ready are both high in one cycle.
  // ready is a function of hold, the valids and starve_cnt only; requesters keep
  // valid/reg/data stable until they see ready.
  always_comb begin
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    b_forced = 1'b0;
    if (!hold) begin
      if (b_valid && (starve_cnt == LIMIT)) begin
        b_ready  = 1'b1;
        b_forced = 1'b1;
      end else if (a_valid) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!hold) begin
      if (b_valid && !b_ready) begin
        starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

  // Writes to register 0 are accepted but never enabled at the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WriteReg <= 1'b0;
      DstReg   <= 4'd0;
      DstData  <= 16'd0;
    end else begin
      WriteReg <= 1'b0;
      if (a_ready) begin
        WriteReg <= (a_reg != 4'd0);
        DstReg   <= a_reg;
        DstData  <= a_data;
      end else if (b_ready) begin
        WriteReg <= (b_reg != 4'd0);
        DstReg   <= b_reg;
        DstData  <= b_data;
      end
    end
  end

endmodule
